data_mem_io: RTL

Memory-stage responder for the pipelined RV32I core. It serves the core's data-memory bus (address, write data, write enable in; read data out) with a word-addressed RAM and a small memory-mapped I/O block: GPIO, a free-running cycle timer with compare interrupt, and a bus-error flag. Reads are combinational so the memory stage needs no stall. Writes commit on the rising clock edge.

---
 rtl/data_mem_io.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/data_mem_io.sv
// Data-memory responder for the RV32I memory stage: word RAM plus an I/O block
// (GPIO, cycle timer with compare interrupt) and a registered bus-error pulse.
module data_mem_io #(
    parameter int unsigned DEPTH   = 256,
    parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_dat,
    input  logic        i_wr_en,
    output logic [31:0] o_rd_dat,
    input  logic [31:0] i_gpio_in,
    output logic [31:0] o_gpio_out,
    output logic        o_timer_irq,
    output logic        o_bus_err
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    // Word offsets of the I/O registers inside the 64-byte block
    localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
    localparam logic [3:0] OFF_MTIME    = 4'd2;
    localparam logic [3:0] OFF_MTIMECMP = 4'd3;
    localparam logic [3:0] OFF_TSTATUS  = 4'd4;
    localparam logic [3:0] OFF_TCTRL    = 4'd5;

    logic [31:0]   mem_r [0:DEPTH-1];
    logic [31:0]   gpio_out_r;
    logic [31:0]   gpio_sync1_r;
    logic [31:0]   gpio_sync2_r;
    logic [31:0]   mtime_r;
    logic [31:0]   mtimecmp_r;
    logic          tctrl_en_r;
    logic          pending_r;
    logic          bus_err_r;

    logic          ram_hit_s;
    logic          io_blk_s;
    logic          io_hit_s;
    logic          misal_s;
    logic          err_s;
    logic [AW-1:0] ram_idx_s;
    logic [3:0]    io_off_s;
    logic          wr_ok_s;
    logic          ram_we_s;
    logic          io_we_s;
    logic          gpio_we_s;
    logic          cmp_we_s;
    logic          tctrl_we_s;
    logic          w1c_s;
    logic          cmp_hit_s;
    logic [31:0]   rd_dat_s;

    // Address decode, alignment check and per-register write strobes
    always_comb begin
        ram_hit_s  = (i_addr < RAM_BYTES);
        io_blk_s   = (i_addr[31:6] == IO_BASE[31:6]);
        io_off_s   = i_addr[5:2];
        io_hit_s   = io_blk_s && (io_off_s <= OFF_TCTRL);
        misal_s    = (i_addr[1:0] != 2'b00);
        err_s      = misal_s || !(ram_hit_s || io_hit_s);
        ram_idx_s  = i_addr[AW+1:2];
        wr_ok_s    = i_wr_en && !err_s && !rst;
        ram_we_s   = wr_ok_s && ram_hit_s;
        io_we_s    = wr_ok_s && io_hit_s && !ram_hit_s;
        gpio_we_s  = io_we_s && (io_off_s == OFF_GPIO_OUT);
        cmp_we_s   = io_we_s && (io_off_s == OFF_MTIMECMP);
        tctrl_we_s = io_we_s && (io_off_s == OFF_TCTRL);
        w1c_s      = io_we_s && (io_off_s == OFF_TSTATUS) && i_wr_dat[0];
        cmp_hit_s  = tctrl_en_r && (mtime_r == mtimecmp_r);
    end

    // Combinational load path; errors and holes read as zero
    always_comb begin
        rd_dat_s = 32'h0000_0000;
        if (err_s) begin
            rd_dat_s = 32'h0000_0000;
        end else if (ram_hit_s) begin
            rd_dat_s = mem_r[ram_idx_s];
        end else begin
            case (io_off_s)
                OFF_GPIO_OUT: rd_dat_s = gpio_out_r;
                OFF_GPIO_IN:  rd_dat_s = gpio_sync2_r;
                OFF_MTIME:    rd_dat_s = mtime_r;
                OFF_MTIMECMP: rd_dat_s = mtimecmp_r;
                OFF_TSTATUS:  rd_dat_s = {31'h0000_0000, pending_r};
                OFF_TCTRL:    rd_dat_s = {31'h0000_0000, tctrl_en_r};
                default:      rd_dat_s = 32'h0000_0000;
            endcase
        end
    end

    // RAM array: no reset, so contents survive a core reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_idx_s] <= i_wr_dat;
        end
    end

    // GPIO output register and two-flop input synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_r   <= 32'h0000_0000;
            gpio_sync1_r <= 32'h0000_0000;
            gpio_sync2_r <= 32'h0000_0000;
        end else begin
            gpio_sync1_r <= i_gpio_in;
            gpio_sync2_r <= gpio_sync1_r;
            if (gpio_we_s) begin
                gpio_out_r <= i_wr_dat;
            end
        end
    end

    // Cycle timer, compare register, enable and sticky pending (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_r    <= 32'h0000_0000;
            mtimecmp_r <= 32'hFFFF_FFFF;
            tctrl_en_r <= 1'b0;
            pending_r  <= 1'b0;
        end else begin
            mtime_r <= mtime_r + 32'd1;
            if (cmp_we_s) begin
                mtimecmp_r <= i_wr_dat;
            end
            if (tctrl_we_s) begin
                tctrl_en_r <= i_wr_dat[0];
            end
            if (cmp_hit_s) begin
                pending_r <= 1'b1;
            end else if (w1c_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Every cycle is an access (load when not storing), so the error flag tracks decode
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= err_s;
        end
    end

    assign o_rd_dat    = rd_dat_s;
    assign o_gpio_out  = gpio_out_r;
    assign o_timer_irq = pending_r;
    assign o_bus_err   = bus_err_r;

endmodule
